// File: rtl/rr_arb_pkg.sv
// Shared types and the rotate-priority search used by the round-robin arbiter.
// rr_next returns the first valid requester after ptr, wrapping back to ptr itself last.
package rr_arb_pkg;

    localparam int N_REQ = 4;

    typedef logic [1:0] req_id_t;

    // Search order is ptr+1, ptr+2, ptr+3, ptr (mod 4); result is don't-care when nothing is valid.
    function automatic req_id_t rr_next(input req_id_t ptr, input logic [N_REQ-1:0] valid);
        req_id_t idx;
        req_id_t res;
        logic    found;
        res   = ptr;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ptr + req_id_t'(k);
            if (!found && valid[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational rotate-priority picker: chooses the next valid requester after ptr_i.
module rr_pick_4
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] valid_i,
    input  req_id_t          ptr_i,
    output req_id_t          grant_o,
    output logic             any_valid_o
);

    assign grant_o     = rr_next(ptr_i, valid_i);
    assign any_valid_o = |valid_i;

endmodule

// File: rtl/rr_arb_mux_4_1.sv
// Round-robin arbiter in front of a 4:1 data mux with a single registered output slot.
// The slot reloads in the same cycle it drains, so a continuously ready sink sees one word per cycle.
module rr_arb_mux_4_1
    import rr_arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       up_valid,
    input  logic [WIDTH-1:0] up_d0,
    input  logic [WIDTH-1:0] up_d1,
    input  logic [WIDTH-1:0] up_d2,
    input  logic [WIDTH-1:0] up_d3,
    output logic [3:0]       up_ready,
    output logic             down_valid,
    output logic [WIDTH-1:0] down_data,
    output logic [1:0]       down_id,
    input  logic             down_ready
);

    req_id_t          ptr_q, ptr_d;
    logic             down_valid_q, down_valid_d;
    logic [WIDTH-1:0] down_data_q, down_data_d;
    req_id_t          down_id_q, down_id_d;

    req_id_t          grant;
    logic             any_valid;
    logic             can_load;
    logic             grant_en;
    logic             up_xfer;
    logic [WIDTH-1:0] up_d_arr [N_REQ];
    logic [WIDTH-1:0] mux_data;

    rr_pick_4 u_pick (
        .valid_i     (up_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .any_valid_o (any_valid)
    );

    assign up_d_arr[0] = up_d0;
    assign up_d_arr[1] = up_d1;
    assign up_d_arr[2] = up_d2;
    assign up_d_arr[3] = up_d3;

    // Slot can take a word when empty or when its current word leaves this cycle.
    assign can_load = !down_valid_q || down_ready;
    assign grant_en = !rst && can_load && any_valid;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign up_ready[gi] = grant_en && (grant == req_id_t'(gi));
        end
    endgenerate

    assign up_xfer  = |(up_valid & up_ready);
    // Only the granted element is selected, so X on idle requesters never reaches the slot.
    assign mux_data = up_d_arr[grant];

    always_comb begin
        ptr_d        = ptr_q;
        down_valid_d = down_valid_q;
        down_data_d  = down_data_q;
        down_id_d    = down_id_q;
        if (up_xfer) begin
            down_data_d  = mux_data;
            down_id_d    = grant;
            down_valid_d = 1'b1;
            ptr_d        = grant;
        end else if (down_valid_q && down_ready) begin
            down_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= req_id_t'(N_REQ - 1);
            down_valid_q <= 1'b0;
            down_data_q  <= '0;
            down_id_q    <= '0;
        end else begin
            ptr_q        <= ptr_d;
            down_valid_q <= down_valid_d;
            down_data_q  <= down_data_d;
            down_id_q    <= down_id_d;
        end
    end

    assign down_valid = down_valid_q;
    assign down_data  = down_data_q;
    assign down_id    = down_id_q;

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Bench for rr_arb_mux_4_1: directed scenarios plus a randomized run against a round-robin model.
module tb_rr_arb_mux_4_1;

    logic       clk;
    logic       rst;
    logic [3:0] up_valid;
    logic [3:0] up_d0, up_d1, up_d2, up_d3;
    logic [3:0] up_ready;
    logic       down_valid;
    logic [3:0] down_data;
    logic [1:0] down_id;
    logic       down_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: "last granted" index plus the contents of the output slot.
    logic       m_valid;
    logic [3:0] m_data;
    int         m_id;
    int         m_last;
    logic [3:0] exp_ready;
    int         exp_grant;

    logic [3:0] sbq [4][$];
    int         waits [4];

    rr_arb_mux_4_1 #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_d0      (up_d0),
        .up_d1      (up_d1),
        .up_d2      (up_d2),
        .up_d3      (up_d3),
        .up_ready   (up_ready),
        .down_valid (down_valid),
        .down_data  (down_data),
        .down_id    (down_id),
        .down_ready (down_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] d_of(input int i);
        case (i)
            0:       return up_d0;
            1:       return up_d1;
            2:       return up_d2;
            default: return up_d3;
        endcase
    endfunction

    task automatic model_comb();
        exp_ready = 4'b0000;
        exp_grant = -1;
        if (!rst && (!m_valid || down_ready)) begin
            for (int k = 1; k <= 4; k++) begin
                int idx;
                idx = (m_last + k) % 4;
                if (exp_grant < 0 && up_valid[idx]) exp_grant = idx;
            end
            if (exp_grant >= 0) exp_ready[exp_grant] = 1'b1;
        end
    endtask

    task automatic model_clock();
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 4'd0;
            m_id    = 0;
            m_last  = 3;
        end else if (exp_grant >= 0) begin
            m_data  = d_of(exp_grant);
            m_id    = exp_grant;
            m_valid = 1'b1;
            m_last  = exp_grant;
        end else if (m_valid && down_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // Inputs are driven just after a posedge; settle lets them propagate before checking up_ready.
    task automatic settle();
        #1;
        model_comb();
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        up_valid   = 4'b0000;
        down_ready = 1'b0;
        settle();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_data(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
        up_d0 = a; up_d1 = b; up_d2 = c; up_d3 = d;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        up_valid   = 4'b1111;
        down_ready = 1'b1;
        set_data(4'h1, 4'h2, 4'h3, 4'h4);
        settle();
        n_tests++;
        if (up_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 0000", up_ready);
        end
        tick();
        n_tests++;
        if (down_valid !== 1'b0 || down_data !== 4'd0 || down_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b d=%h id=%0d want v=0 d=0 id=0",
                     down_valid, down_data, down_id);
        end
        rst = 1'b0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_all_valid();
        logic [3:0] dv [4];
        do_reset();
        for (int i = 0; i < 4; i++) dv[i] = 4'($urandom_range(0, 15));
        set_data(dv[0], dv[1], dv[2], dv[3]);
        up_valid   = 4'b1111;
        down_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            settle();
            n_tests++;
            if (up_ready !== 4'(1 << (k % 4))) begin
                n_fail++;
                $display("FAIL all_valid_ready[%0d]: got %b want %b", k, up_ready, 4'(1 << (k % 4)));
            end
            tick();
            n_tests++;
            if (down_valid !== 1'b1 || down_id !== 2'(k % 4) || down_data !== dv[k % 4]) begin
                n_fail++;
                $display("FAIL all_valid_out[%0d]: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                         k, down_valid, down_id, down_data, k % 4, dv[k % 4]);
            end
            $display("[TB] all_valid cycle %0d id=%0d data=%h", k, down_id, down_data);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_data(4'h0, 4'h0, 4'h7, 4'h0);
        up_valid   = 4'b0100;
        down_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            n_tests++;
            if (up_ready !== 4'b0100) begin
                n_fail++;
                $display("FAIL single_ready[%0d]: got %b want 0100", k, up_ready);
            end
            tick();
            n_tests++;
            if (down_valid !== 1'b1 || down_id !== 2'd2 || down_data !== 4'h7) begin
                n_fail++;
                $display("FAIL single_out[%0d]: got v=%b id=%0d d=%h want v=1 id=2 d=7",
                         k, down_valid, down_id, down_data);
            end
            $display("[TB] single cycle %0d id=%0d data=%h", k, down_id, down_data);
        end
    endtask

    task automatic test_hold();
        logic [3:0] dv [4];
        do_reset();
        for (int i = 0; i < 4; i++) dv[i] = 4'($urandom_range(0, 15));
        set_data(dv[0], dv[1], dv[2], dv[3]);
        up_valid   = 4'b1111;
        down_ready = 1'b1;
        settle();
        tick();
        down_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            n_tests++;
            if (up_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL hold_ready[%0d]: got %b want 0000", k, up_ready);
            end
            tick();
            n_tests++;
            if (down_valid !== 1'b1 || down_id !== 2'd0 || down_data !== dv[0]) begin
                n_fail++;
                $display("FAIL hold_out[%0d]: got v=%b id=%0d d=%h want v=1 id=0 d=%h",
                         k, down_valid, down_id, down_data, dv[0]);
            end
        end
        down_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            settle();
            tick();
            n_tests++;
            if (down_valid !== 1'b1 || down_id !== 2'(k % 4) || down_data !== dv[k % 4]) begin
                n_fail++;
                $display("FAIL hold_resume[%0d]: got id=%0d d=%h want id=%0d d=%h",
                         k, down_id, down_data, k % 4, dv[k % 4]);
            end
        end
        $display("[TB] test_hold done");
    endtask

    task automatic test_x_data();
        do_reset();
        set_data(4'h5, 4'hA, 4'h3, 4'bxxxx);
        up_valid   = 4'b0011;
        down_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            settle();
            tick();
            n_tests++;
            if ($isunknown(down_data) || down_id !== 2'(k % 2) || down_data !== ((k % 2 == 0) ? 4'h5 : 4'hA)) begin
                n_fail++;
                $display("FAIL x_data[%0d]: got id=%0d d=%h want id=%0d d=%h",
                         k, down_id, down_data, k % 2, (k % 2 == 0) ? 4'h5 : 4'hA);
            end
        end
        $display("[TB] test_x_data done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_data(4'h9, 4'hC, 4'h2, 4'hE);
        up_valid   = 4'b1111;
        down_ready = 1'b1;
        settle();
        tick();
        settle();
        tick();
        down_ready = 1'b0;
        rst        = 1'b1;
        settle();
        n_tests++;
        if (up_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_ready: got %b want 0000", up_ready);
        end
        tick();
        rst = 1'b0;
        n_tests++;
        if (down_valid !== 1'b0 || down_id !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_mid_state: got v=%b id=%0d want v=0 id=0", down_valid, down_id);
        end
        down_ready = 1'b1;
        settle();
        n_tests++;
        if (up_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_mid_first_grant: got %b want 0001", up_ready);
        end
        tick();
        n_tests++;
        if (down_valid !== 1'b1 || down_id !== 2'd0 || down_data !== 4'h9) begin
            n_fail++;
            $display("FAIL rst_mid_first_word: got v=%b id=%0d d=%h want v=1 id=0 d=9",
                     down_valid, down_id, down_data);
        end
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_random();
        logic [3:0] sv;
        logic [3:0] sd [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sbq[i].delete();
            waits[i] = 0;
            sd[i]    = 4'd0;
        end
        sv = 4'b0000;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            up_valid   = sv;
            up_d0      = sv[0] ? sd[0] : 4'bxxxx;
            up_d1      = sv[1] ? sd[1] : 4'bxxxx;
            up_d2      = sv[2] ? sd[2] : 4'bxxxx;
            up_d3      = sv[3] ? sd[3] : 4'bxxxx;
            down_ready = ($urandom_range(0, 9) < 7);
            settle();
            n_tests++;
            if (up_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b want %b", cyc, up_ready, exp_ready);
            end
            if (down_valid === 1'b1 && down_ready) begin
                n_tests++;
                if (sbq[down_id].size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_dup[%0d]: got word id=%0d d=%h want none pending", cyc, down_id, down_data);
                end else if (down_data !== sbq[down_id][0]) begin
                    n_fail++;
                    $display("FAIL rand_order[%0d]: got id=%0d d=%h want d=%h", cyc, down_id, down_data, sbq[down_id][0]);
                    void'(sbq[down_id].pop_front());
                end else begin
                    void'(sbq[down_id].pop_front());
                end
            end
            if (|(up_valid & up_ready)) begin
                for (int i = 0; i < 4; i++) begin
                    if (up_ready[i]) begin
                        waits[i] = 0;
                    end else if (up_valid[i]) begin
                        waits[i]++;
                        n_tests++;
                        if (waits[i] > 3) begin
                            n_fail++;
                            $display("FAIL rand_fair[%0d]: req %0d waited %0d grants want <=3", cyc, i, waits[i]);
                        end
                    end
                end
            end
            if (exp_grant >= 0) sbq[exp_grant].push_back(sd[exp_grant]);
            tick();
            n_tests++;
            if (down_valid !== m_valid || down_id !== 2'(m_id) || down_data !== m_data) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: got v=%b id=%0d d=%h want v=%b id=%0d d=%h",
                         cyc, down_valid, down_id, down_data, m_valid, m_id, m_data);
            end
            for (int i = 0; i < 4; i++) begin
                if (exp_ready[i]) sv[i] = 1'b0;
                if (!sv[i] && $urandom_range(0, 1) == 1) begin
                    sv[i] = 1'b1;
                    sd[i] = 4'($urandom_range(0, 15));
                end
            end
        end
        up_valid   = 4'b0000;
        down_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            settle();
            if (down_valid === 1'b1 && sbq[down_id].size() != 0) void'(sbq[down_id].pop_front());
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (sbq[i].size() != 0) begin
                n_fail++;
                $display("FAIL rand_loss: req %0d got %0d undelivered words want 0", i, sbq[i].size());
            end
        end
        $display("[TB] test_random done");
    endtask

    initial begin
        rst        = 1'b1;
        up_valid   = 4'b0000;
        down_ready = 1'b0;
        set_data(4'h0, 4'h0, 4'h0, 4'h0);
        m_valid    = 1'b0;
        m_data     = 4'd0;
        m_id       = 0;
        m_last     = 3;
        test_reset();
        test_all_valid();
        test_single();
        test_hold();
        test_x_data();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
